ir_nec_decoder: RTL and testbench

// Decodes the demodulated IR receiver output (NEC protocol) into the 8-bit button code that drives the
// top-level mode FSM (IR_button), plus valid/repeat/error strobes. Sits between the IR receiver pin and
// the mode FSM. It measures mark/space widths in microseconds and validates the leader, 32 data bits
// and the stop burst. Sequential: input synchroniser, us prescaler, width counter, frame state machine.

---
 rtl/ir_pkg.sv | 41 ++++
 rtl/ir_nec_decoder_if.sv | 27 ++
 rtl/ir_pulse_timer.sv | 47 ++++
 rtl/ir_nec_decoder.sv | 183 ++++++++++++++++++
 tb/tb_ir_nec_decoder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ir_pkg.sv
// Shared types and timing windows for the NEC IR decoder.
// Windows are in microseconds, inclusive on both ends.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_MARK,
    ERROR
  } ir_state_t;

  localparam logic [13:0] LEAD_MIN = 14'd8000;
  localparam logic [13:0] LEAD_MAX = 14'd10000;
  localparam logic [13:0] FRM_MIN  = 14'd4000;
  localparam logic [13:0] FRM_MAX  = 14'd5000;
  localparam logic [13:0] REP_MIN  = 14'd2000;
  localparam logic [13:0] REP_MAX  = 14'd2500;
  localparam logic [13:0] MARK_MIN = 14'd400;
  localparam logic [13:0] MARK_MAX = 14'd750;
  localparam logic [13:0] ZERO_MIN = 14'd400;
  localparam logic [13:0] ZERO_MAX = 14'd750;
  localparam logic [13:0] ONE_MIN  = 14'd1400;
  localparam logic [13:0] ONE_MAX  = 14'd1900;

  localparam logic [7:0] BTN_CAM  = 8'h0F;
  localparam logic [7:0] BTN_IDLE = 8'h10;
  localparam logic [7:0] BTN_IR   = 8'h13;

  function automatic logic in_win(
    input logic [13:0] w,
    input logic [13:0] lo,
    input logic [13:0] hi
  );
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_nec_decoder_if.sv
// Decoded IR result bundle: held button/address
// plus one-cycle valid/repeat/error strobes.
interface ir_nec_decoder_if;

  logic [7:0] IR_button;
  logic       ir_valid;
  logic       ir_repeat;
  logic       ir_error;
  logic [7:0] ir_addr;

  modport master (
    output IR_button,
    output ir_valid,
    output ir_repeat,
    output ir_error,
    output ir_addr
  );

  modport slave (
    input IR_button,
    input ir_valid,
    input ir_repeat,
    input ir_error,
    input ir_addr
  );

endinterface

// File: rtl/ir_pulse_timer.sv
// Receiver front end: 2-flop synchroniser, 1 us prescaler,
// edge detect and saturating mark/space width counter.
module ir_pulse_timer #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        ir_rx,
  output logic        level,
  output logic        rise,
  output logic        fall,
  output logic        tick,
  output logic [13:0] width_us
);

  localparam int unsigned RAW = CLK_HZ / 1_000_000;
  localparam int unsigned DIV = (RAW > 1) ? RAW : 1;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [1:0]    sync;
  logic          prev;
  logic [PW-1:0] pcnt;

  assign level = sync[1];
  assign rise  = sync[1] & ~prev;
  assign fall  = ~sync[1] & prev;
  assign tick  = (pcnt == PW'(DIV - 1));

  // Sync flops reset high so an idle line gives no edge.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= 2'b11;
      prev     <= 1'b1;
      pcnt     <= '0;
      width_us <= '0;
    end else begin
      sync <= {sync[0], ir_rx};
      prev <= sync[1];
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (rise || fall)
        width_us <= '0;
      else if (tick && (width_us != '1))
        width_us <= width_us + 14'd1;
    end
  end

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: validates leader, 32 data bits and
// stop burst, holds button/address and pulses the strobes.
module ir_nec_decoder
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter bit          CHECK_ADDR = 1'b1,
  parameter int unsigned CLEAR_MS   = 0,
  parameter int unsigned TOUT_US    = 12000
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic ir_rx,
  ir_nec_decoder_if.master ir
);

  localparam logic [13:0] TOUT = 14'(TOUT_US);
  localparam logic [15:0] CLR  = 16'(CLEAR_MS);

  logic        level;
  logic        rise;
  logic        fall;
  logic        tick;
  logic [13:0] width_us;

  ir_state_t   state;
  logic [4:0]  bit_cnt;
  logic [31:0] shreg;
  logic        last_ok;
  logic [7:0]  button_q;
  logic [7:0]  addr_q;
  logic        valid_q;
  logic        repeat_q;
  logic        error_q;

  logic [9:0]  us_cnt;
  logic [15:0] ms_cnt;
  logic        ms_hit;

  logic mark_ok, zero_ok, one_ok;
  logic lead_ok, frm_ok, rep_ok;
  logic chk_ok, tout;

  ir_pulse_timer #(
    .CLK_HZ(CLK_HZ)
  ) u_timer (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .ir_rx   (ir_rx),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .tick    (tick),
    .width_us(width_us)
  );

  assign lead_ok = in_win(width_us, LEAD_MIN, LEAD_MAX);
  assign frm_ok  = in_win(width_us, FRM_MIN, FRM_MAX);
  assign rep_ok  = in_win(width_us, REP_MIN, REP_MAX);
  assign mark_ok = in_win(width_us, MARK_MIN, MARK_MAX);
  assign zero_ok = in_win(width_us, ZERO_MIN, ZERO_MAX);
  assign one_ok  = in_win(width_us, ONE_MIN, ONE_MAX);

  // Air order is addr, ~addr, cmd, ~cmd, LSB first.
  assign chk_ok = (shreg[23:16] == ~shreg[31:24]) &&
                  (!CHECK_ADDR ||
                   (shreg[7:0] == ~shreg[15:8]));

  assign tout = (state != IDLE) && (state != ERROR) &&
                (width_us > TOUT);

  assign ms_hit = (CLEAR_MS != 0) && tick &&
                  (us_cnt == 10'd999) &&
                  (ms_cnt == CLR - 16'd1);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      us_cnt <= '0;
      ms_cnt <= '0;
    end else if (valid_q || repeat_q) begin
      us_cnt <= '0;
      ms_cnt <= '0;
    end else if (tick && (ms_cnt != CLR)) begin
      if (us_cnt == 10'd999) begin
        us_cnt <= '0;
        ms_cnt <= ms_cnt + 16'd1;
      end else begin
        us_cnt <= us_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      last_ok  <= 1'b0;
      button_q <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      error_q  <= 1'b0;
      if (ms_hit) begin
        button_q <= '0;
        last_ok  <= 1'b0;
      end
      if (tout) begin
        state   <= ERROR;
        error_q <= 1'b1;
      end else begin
        unique case (state)
          IDLE: if (fall) state <= LEAD_MARK;
          LEAD_MARK: if (rise) begin
            state   <= lead_ok ? LEAD_SPACE : ERROR;
            error_q <= !lead_ok;
          end
          LEAD_SPACE: if (fall) begin
            bit_cnt <= '0;
            if (frm_ok) begin
              state <= BIT_MARK;
            end else if (rep_ok) begin
              state <= REP_MARK;
            end else begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
          BIT_MARK: if (rise) begin
            state   <= mark_ok ? BIT_SPACE : ERROR;
            error_q <= !mark_ok;
          end
          BIT_SPACE: if (fall) begin
            if (zero_ok || one_ok) begin
              shreg   <= {one_ok, shreg[31:1]};
              bit_cnt <= bit_cnt + 5'd1;
              state   <= (bit_cnt == 5'd31) ?
                         STOP_MARK : BIT_MARK;
            end else begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
          STOP_MARK: if (rise) begin
            if (mark_ok && chk_ok) begin
              button_q <= shreg[23:16];
              addr_q   <= shreg[7:0];
              valid_q  <= 1'b1;
              last_ok  <= 1'b1;
              state    <= IDLE;
            end else begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
          REP_MARK: if (rise) begin
            if (mark_ok && last_ok) begin
              repeat_q <= 1'b1;
              state    <= IDLE;
            end else begin
              state   <= ERROR;
              error_q <= 1'b1;
            end
          end
          // Edges are ignored until the line idles high.
          ERROR:
            if (level && (width_us >= TOUT)) state <= IDLE;
        endcase
      end
    end
  end

  assign ir.IR_button = button_q;
  assign ir.ir_addr   = addr_q;
  assign ir.ir_valid  = valid_q;
  assign ir.ir_repeat = repeat_q;
  assign ir.ir_error  = error_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Bench for ir_nec_decoder: directed and random NEC frames
// scored against a frame-level width-list model.
module tb_ir_nec_decoder;

  logic clk_50  = 1'b0;
  logic reset_n = 1'b0;
  logic ir_rx   = 1'b1;

  int total = 0;
  int bad   = 0;
  int n_val = 0;
  int n_rep = 0;
  int n_err = 0;
  bit prev_any = 1'b0;

  int m_button = 0;
  int m_addr   = 0;
  bit m_last   = 1'b0;

  int wq[$];

  ir_nec_decoder_if ir ();

  ir_nec_decoder #(
    .CLK_HZ    (1_000_000),
    .CHECK_ADDR(1'b1),
    .CLEAR_MS  (0),
    .TOUT_US   (12000)
  ) dut (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .ir_rx  (ir_rx),
    .ir     (ir)
  );

  always #500 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    if (ir.ir_valid)  n_val++;
    if (ir.ir_repeat) n_rep++;
    if (ir.ir_error)  n_err++;
    if (ir.ir_valid || ir.ir_repeat || ir.ir_error) begin
      total++;
      assert ($countones({ir.ir_valid, ir.ir_repeat,
                          ir.ir_error}) == 1 && !prev_any)
      else begin
        bad++;
        $error("FAIL strobe_shape got=%b%b%b prev=%0b want=one 1-cycle",
               ir.ir_valid, ir.ir_repeat, ir.ir_error, prev_any);
      end
    end
    prev_any = ir.ir_valid || ir.ir_repeat || ir.ir_error;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic bit win(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic int jit(int nom, int j);
    return nom + int'($urandom_range(0, 2 * j)) - j;
  endfunction

  task automatic build(input logic [7:0] a, input logic [7:0] ai,
                       input logic [7:0] c, input logic [7:0] ci,
                       input int j);
    logic [31:0] d;
    d = {ci, c, ai, a};
    wq.delete();
    wq.push_back(jit(9000, 4 * j));
    wq.push_back(jit(4500, 2 * j));
    for (int i = 0; i < 32; i++) begin
      wq.push_back(jit(560, j));
      wq.push_back(jit(d[i] ? 1690 : 560, j));
    end
    wq.push_back(jit(560, j));
  endtask

  task automatic build_rep();
    wq.delete();
    wq.push_back(9000);
    wq.push_back(2250);
    wq.push_back(560);
  endtask

  // Classify a whole mark/space list: 0 valid, 1 repeat, 2 error.
  task automatic model_apply(output int kind);
    logic [31:0] d;
    kind = 2;
    d = '0;
    if (wq.size() < 3 || !win(wq[0], 8000, 10000)) return;
    if (wq.size() == 3) begin
      if (win(wq[1], 2000, 2500) && win(wq[2], 400, 750) && m_last)
        kind = 1;
      return;
    end
    if (wq.size() != 67 || !win(wq[1], 4000, 5000)) return;
    for (int i = 0; i < 32; i++) begin
      if (!win(wq[2 + 2 * i], 400, 750)) return;
      if (win(wq[3 + 2 * i], 1400, 1900)) d[i] = 1'b1;
      else if (!win(wq[3 + 2 * i], 400, 750)) return;
    end
    if (!win(wq[66], 400, 750)) return;
    if (d[23:16] != ~d[31:24] || d[7:0] != ~d[15:8]) return;
    kind = 0;
    m_button = int'(d[23:16]);
    m_addr = int'(d[7:0]);
    m_last = 1'b1;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      ir_rx = (i % 2 == 1);
      repeat (wq[i]) @(negedge clk_50);
    end
    ir_rx = 1'b1;
  endtask

  task automatic run(input string tag, input int gap, input bit lat);
    int kind, v0, r0, e0, g;
    v0 = n_val;
    r0 = n_rep;
    e0 = n_err;
    model_apply(kind);
    send(wq.size());
    if (lat) begin
      repeat (2) @(posedge clk_50);
      #1;
      chk({tag, "_lat2"}, 32'(ir.ir_valid), 0);
      @(posedge clk_50);
      #1;
      chk({tag, "_lat3"}, 32'(ir.ir_valid), 32'(kind == 0));
      chk({tag, "_lat3_btn"}, 32'(ir.IR_button), m_button);
    end
    g = (kind == 2 && gap < 12500) ? 12500 : gap;
    repeat (g) @(negedge clk_50);
    chk({tag, "_nval"}, n_val - v0, 32'(kind == 0));
    chk({tag, "_nrep"}, n_rep - r0, 32'(kind == 1));
    chk({tag, "_nerr"}, n_err - e0, 32'(kind == 2));
    chk({tag, "_btn"}, 32'(ir.IR_button), m_button);
    chk({tag, "_addr"}, 32'(ir.ir_addr), m_addr);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_50);
    chk({tag, "_btn"}, 32'(ir.IR_button), 0);
    chk({tag, "_addr"}, 32'(ir.ir_addr), 0);
    chk({tag, "_strb"},
        32'({ir.ir_valid, ir.ir_repeat, ir.ir_error}), 0);
    reset_n = 1'b1;
    m_button = 0;
    m_addr = 0;
    m_last = 1'b0;
  endtask

  initial begin
    int v0, r0, e0;
    do_reset("rst0");
    repeat (100) @(negedge clk_50);

    build(8'h00, 8'hFF, 8'h0F, 8'hF0, 0);
    run("cam", 50, 1'b1);

    build(8'h00, 8'hFF, 8'h13, 8'hEC, 0);
    run("ir13", 40000, 1'b1);
    build_rep();
    run("rep13", 50, 1'b0);

    do_reset("rst1");
    repeat (20) @(negedge clk_50);
    build_rep();
    run("rep_nofrm", 12500, 1'b0);

    build(8'h00, 8'hFF, 8'h0F, 8'hF0, 0);
    run("cam2", 50, 1'b0);
    build(8'h00, 8'hFF, 8'h10, 8'hEE, 0);
    run("bad_inv", 12500, 1'b0);

    build(8'h20, 8'hDF, 8'h10, 8'hEF, 0);
    wq[13] = 2100;
    run("long_one", 12500, 1'b0);
    build(8'h00, 8'hFF, 8'h10, 8'hEF, 0);
    run("idle10", 50, 1'b0);

    v0 = n_val;
    r0 = n_rep;
    e0 = n_err;
    build(8'h00, 8'hFF, 8'h0F, 8'hF0, 0);
    send(37);
    repeat (200) @(negedge clk_50);
    do_reset("rst_mid");
    repeat (2000) @(negedge clk_50);
    chk("mid_nostrobe", (n_val - v0) + (n_rep - r0) + (n_err - e0), 0);
    run("after_rst", 50, 1'b1);

    for (int k = 0; k < 3; k++) begin
      logic [7:0] a, c, ci;
      a = 8'($urandom);
      c = 8'($urandom);
      ci = ~c;
      if ($urandom_range(0, 2) == 0)
        ci = ci ^ 8'(1 << $urandom_range(0, 7));
      build(a, ~a, c, ci, 60);
      run("rnd", 1000, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        build_rep();
        run("rnd_rep", 50, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
